spi_master_byte: RTL and testbench

Single-byte SPI master (mode 0: SCLK idle low, MSB first, data valid on SCLK rising edge) that drives the board's SPI slave receiver from the FPGA-side control logic. Each accepted request performs one complete CS-framed 8-bit transfer. It shifts the request byte out on MOSI, captures the slave's reply from MISO and reports it with a one-cycle done pulse. The block sits directly upstream of the SPI slave that shifts MOSI into its LED/PWM/display register.

---
 rtl/spi_master_byte.sv | 163 ++++++++++++++++
 tb/tb_spi_master_byte.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/spi_master_byte.sv
// Single-byte SPI master, mode 0 (SCLK idle low, MSB first), CS-framed transfers.
// Every output is a register, so no input reaches an output combinationally.
module spi_master_byte #(
   parameter int unsigned CLK_DIV = 4
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       start,
   input  logic [7:0] tx_data,
   output logic       busy,
   output logic       done,
   output logic [7:0] rx_data,
   output logic       sclk,
   output logic       mosi,
   input  logic       miso,
   output logic       cs_n
);

   localparam int unsigned CNT_W = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam int unsigned BIT_W = 3;

   typedef enum logic [2:0] {
      IDLE     = 3'd0,
      SETUP    = 3'd1,
      SHIFT_HI = 3'd2,
      SHIFT_LO = 3'd3,
      HOLD     = 3'd4,
      GAP      = 3'd5
   } state_t;

   state_t             state_q, state_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIT_W-1:0]   bit_q, bit_d;
   logic [7:0]         tx_q, tx_d;
   logic [7:0]         rx_sr_q, rx_sr_d;
   logic [7:0]         rx_data_q, rx_data_d;
   logic               sclk_q, sclk_d;
   logic               cs_n_q, cs_n_d;
   logic               mosi_q, mosi_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               phase_end;

   // Phase timer expires on the last cycle of a CLK_DIV-long phase
   assign phase_end = (cnt_q == CNT_W'(CLK_DIV - 1));

   // State register with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         bit_q     <= '0;
         tx_q      <= '0;
         rx_sr_q   <= '0;
         rx_data_q <= '0;
         sclk_q    <= 1'b0;
         cs_n_q    <= 1'b1;
         mosi_q    <= 1'b0;
         busy_q    <= 1'b0;
         done_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         bit_q     <= bit_d;
         tx_q      <= tx_d;
         rx_sr_q   <= rx_sr_d;
         rx_data_q <= rx_data_d;
         sclk_q    <= sclk_d;
         cs_n_q    <= cs_n_d;
         mosi_q    <= mosi_d;
         busy_q    <= busy_d;
         done_q    <= done_d;
      end
   end

   // Next-state and next-output logic for the transfer sequence
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      bit_d     = bit_q;
      tx_d      = tx_q;
      rx_sr_d   = rx_sr_q;
      rx_data_d = rx_data_q;
      sclk_d    = sclk_q;
      cs_n_d    = cs_n_q;
      mosi_d    = mosi_q;
      busy_d    = busy_q;
      done_d    = 1'b0;

      if (state_q != IDLE) begin
         cnt_d = phase_end ? '0 : CNT_W'(cnt_q + 1'b1);
      end

      case (state_q)
         IDLE: begin
            sclk_d = 1'b0;
            cs_n_d = 1'b1;
            if (start) begin
               // MSB goes straight to mosi; the shift register keeps the remaining bits
               tx_d    = {tx_data[6:0], 1'b0};
               bit_d   = '0;
               cnt_d   = '0;
               cs_n_d  = 1'b0;
               busy_d  = 1'b1;
               mosi_d  = tx_data[7];
               state_d = SETUP;
            end
         end
         SETUP: begin
            if (phase_end) begin
               sclk_d  = 1'b1;
               state_d = SHIFT_HI;
            end
         end
         SHIFT_HI: begin
            if (phase_end) begin
               rx_sr_d = {rx_sr_q[6:0], miso};
               sclk_d  = 1'b0;
               if (bit_q == BIT_W'(7)) begin
                  state_d = HOLD;
               end else begin
                  mosi_d  = tx_q[7];
                  tx_d    = {tx_q[6:0], 1'b0};
                  bit_d   = BIT_W'(bit_q + 1'b1);
                  state_d = SHIFT_LO;
               end
            end
         end
         SHIFT_LO: begin
            if (phase_end) begin
               sclk_d  = 1'b1;
               state_d = SHIFT_HI;
            end
         end
         HOLD: begin
            if (phase_end) begin
               cs_n_d    = 1'b1;
               mosi_d    = 1'b0;
               rx_data_d = rx_sr_q;
               done_d    = 1'b1;
               state_d   = GAP;
            end
         end
         GAP: begin
            if (phase_end) begin
               busy_d  = 1'b0;
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   assign busy    = busy_q;
   assign done    = done_q;
   assign rx_data = rx_data_q;
   assign sclk    = sclk_q;
   assign mosi    = mosi_q;
   assign cs_n    = cs_n_q;

endmodule

// File: tb/tb_spi_master_byte.sv
// Directed bench for spi_master_byte at CLK_DIV=4 and CLK_DIV=1.
module tb_spi_master_byte;

   logic       clk;
   logic       rst_n;
   logic       start4, start1;
   logic [7:0] tx4, tx1;
   logic       busy4, done4, sclk4, mosi4, miso4, cs_n4;
   logic       busy1, done1, sclk1, mosi1, miso1, cs_n1;
   logic [7:0] rx4, rx1;
   logic [7:0] reply4;
   logic [3:0] fcnt4;

   int checks   = 0;
   int failures = 0;

   // monitor results
   int         m_rises, m_done_cyc, m_done_cnt, m_busy_fall;
   int         m_cs_low, m_cs_high, m_rise_err, m_cs_clk_err;
   logic [7:0] m_mosi, m_rx;

   spi_master_byte #(.CLK_DIV(4)) dut4 (
      .clk(clk), .rst_n(rst_n), .start(start4), .tx_data(tx4),
      .busy(busy4), .done(done4), .rx_data(rx4), .sclk(sclk4),
      .mosi(mosi4), .miso(miso4), .cs_n(cs_n4)
   );

   spi_master_byte #(.CLK_DIV(1)) dut1 (
      .clk(clk), .rst_n(rst_n), .start(start1), .tx_data(tx1),
      .busy(busy1), .done(done1), .rx_data(rx1), .sclk(sclk1),
      .mosi(mosi1), .miso(miso1), .cs_n(cs_n1)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Mode-0 slave: present next reply bit after each falling sclk, MSB first
   always @(negedge sclk4 or posedge cs_n4) begin
      if (cs_n4) fcnt4 <= 4'd0;
      else       fcnt4 <= fcnt4 + 4'd1;
   end
   assign miso4 = (cs_n4 || fcnt4 > 4'd7) ? 1'b0 : reply4[3'(4'd7 - fcnt4)];
   assign miso1 = 1'b1;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Observe one DUT for ncyc cycles, starting in the current cycle numbered 1
   task automatic monitor(input bit use1, input int ncyc);
      logic s, cs, mo, dn, bz, prev_s;
      logic [7:0] rx;
      int div;
      div = use1 ? 1 : 4;
      m_rises = 0; m_mosi = '0; m_done_cyc = -1; m_done_cnt = 0; m_rx = '0;
      m_busy_fall = -1; m_cs_low = 0; m_cs_high = 0; m_rise_err = 0; m_cs_clk_err = 0;
      prev_s = 1'b0;
      for (int c = 1; c <= ncyc; c++) begin
         s  = use1 ? sclk1 : sclk4;
         cs = use1 ? cs_n1 : cs_n4;
         mo = use1 ? mosi1 : mosi4;
         dn = use1 ? done1 : done4;
         bz = use1 ? busy1 : busy4;
         rx = use1 ? rx1   : rx4;
         if (s && !prev_s) begin
            if (m_rises >= 8 || c != 1 + div * (1 + 2 * m_rises)) m_rise_err++;
            m_rises++;
            m_mosi = {m_mosi[6:0], mo};
         end
         if (s && cs) m_cs_clk_err++;
         if (cs) m_cs_high++; else m_cs_low++;
         if (dn) begin
            m_done_cnt++;
            if (m_done_cyc < 0) begin
               m_done_cyc = c;
               m_rx = rx;
            end
         end
         if (!bz && m_busy_fall < 0) m_busy_fall = c;
         prev_s = s;
         if (c < ncyc) tick();
      end
   endtask

   initial begin
      rst_n = 1'b0; start4 = 1'b0; start1 = 1'b0; tx4 = '0; tx1 = '0; reply4 = '0;
      tick(); tick();
      rst_n = 1'b1;

      // reset state
      check("rst_cs_n", 32'(cs_n4), 32'd1);
      check("rst_sclk", 32'(sclk4), 32'd0);
      check("rst_mosi", 32'(mosi4), 32'd0);
      check("rst_busy", 32'(busy4), 32'd0);
      check("rst_done", 32'(done4), 32'd0);
      check("rst_rx",   32'(rx4),   32'h00);
      check("rst1_cs_n", 32'(cs_n1), 32'd1);
      check("rst1_rx",  32'(rx1),   32'h00);

      // idle: no sclk or cs activity for 100 cycles
      monitor(1'b0, 100);
      check("idle_rises", 32'(m_rises), 32'd0);
      check("idle_cs_low", 32'(m_cs_low), 32'd0);
      check("idle_done", 32'(m_done_cnt), 32'd0);

      // A5 out, 3C back at CLK_DIV=4
      tick();
      reply4 = 8'h3C; tx4 = 8'hA5; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      check("a5_cyc1_cs_n", 32'(cs_n4), 32'd0);
      check("a5_cyc1_busy", 32'(busy4), 32'd1);
      check("a5_cyc1_mosi", 32'(mosi4), 32'd1);
      monitor(1'b0, 73);
      check("a5_rises",     32'(m_rises),     32'd8);
      check("a5_rise_time", 32'(m_rise_err),  32'd0);
      check("a5_mosi",      32'(m_mosi),      32'hA5);
      check("a5_done_cyc",  32'(m_done_cyc),  32'd69);
      check("a5_done_cnt",  32'(m_done_cnt),  32'd1);
      check("a5_rx",        32'(m_rx),        32'h3C);
      check("a5_busy_fall", 32'(m_busy_fall), 32'd73);
      check("a5_cs_low",    32'(m_cs_low),    32'd68);
      check("a5_cs_clk",    32'(m_cs_clk_err), 32'd0);
      check("a5_rx_hold",   32'(rx4),         32'h3C);

      // start held high: 01 then FF, tx_data changed right after acceptance
      tick();
      reply4 = 8'h5A; tx4 = 8'h01; start4 = 1'b1;
      tick();
      tx4 = 8'hFF;
      monitor(1'b0, 73);
      check("b2b1_mosi",    32'(m_mosi),     32'h01);
      check("b2b1_rises",   32'(m_rises),    32'd8);
      check("b2b1_done",    32'(m_done_cyc), 32'd69);
      check("b2b1_rx",      32'(m_rx),       32'h5A);
      check("b2b1_gap",     32'(m_cs_high),  32'd5);
      check("b2b1_cs_clk",  32'(m_cs_clk_err), 32'd0);
      tick();
      check("b2b2_cs_n",    32'(cs_n4),      32'd0);
      monitor(1'b0, 73);
      start4 = 1'b0;
      check("b2b2_mosi",    32'(m_mosi),     32'hFF);
      check("b2b2_rises",   32'(m_rises),    32'd8);
      check("b2b2_done",    32'(m_done_cyc), 32'd69);
      check("b2b2_done_cnt", 32'(m_done_cnt), 32'd1);
      check("b2b2_rx",      32'(m_rx),       32'h5A);
      check("b2b2_busy_fall", 32'(m_busy_fall), 32'd73);
      tick();
      check("b2b_no_third", 32'(cs_n4),      32'd1);

      // reset at cycle 30 of a transfer
      tick();
      reply4 = 8'h3C; tx4 = 8'hA5; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      monitor(1'b0, 30);
      check("abort_pre_done", 32'(m_done_cnt), 32'd0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      check("abort_cs_n", 32'(cs_n4), 32'd1);
      check("abort_sclk", 32'(sclk4), 32'd0);
      check("abort_busy", 32'(busy4), 32'd0);
      check("abort_done", 32'(done4), 32'd0);
      check("abort_rx",   32'(rx4),   32'h00);
      monitor(1'b0, 100);
      check("abort_quiet_done",  32'(m_done_cnt), 32'd0);
      check("abort_quiet_rises", 32'(m_rises),    32'd0);

      // transfer after abort completes normally
      reply4 = 8'h96; tx4 = 8'hC3; start4 = 1'b1;
      tick();
      start4 = 1'b0;
      monitor(1'b0, 73);
      check("post_mosi",  32'(m_mosi),      32'hC3);
      check("post_rises", 32'(m_rises),     32'd8);
      check("post_done",  32'(m_done_cyc),  32'd69);
      check("post_rx",    32'(m_rx),        32'h96);
      check("post_busy_fall", 32'(m_busy_fall), 32'd73);

      // CLK_DIV=1, tx 80, miso tied high
      tx1 = 8'h80; start1 = 1'b1;
      tick();
      start1 = 1'b0;
      check("d1_cyc1_mosi", 32'(mosi1), 32'd1);
      monitor(1'b1, 19);
      check("d1_rises",     32'(m_rises),     32'd8);
      check("d1_rise_time", 32'(m_rise_err),  32'd0);
      check("d1_mosi",      32'(m_mosi),      32'h80);
      check("d1_done",      32'(m_done_cyc),  32'd18);
      check("d1_rx",        32'(m_rx),        32'hFF);
      check("d1_busy_fall", 32'(m_busy_fall), 32'd19);
      check("d1_cs_low",    32'(m_cs_low),    32'd17);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
